regfile_port_sequencer: RTL
===========================

Name: regfile_port_sequencer

Overview:
- Initiator side of the register-file port: drives the shared rs1/rd address port, rs2, write enable and write data.
- Arbitrates between operand-read requests and write-back requests.
- Buffers write-backs in a small FIFO and drains them into the register file in cycles with no read. The register file switches its rs1 port to rd when its enable is high.
- Forwards pending write data to reads so reads never see stale values. Sits between decode/writeback and the register file.

Parameters:
- DEPTH, 4, write-back buffer entries (power of two, >=2)
- STARVE_LIMIT, 8, consecutive drain-blocked cycles before a forced drain (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  operand read request
- rd_req_ready  out  1  read accepted this cycle
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- rsp_valid  out  1  read response valid (registered)
- RegR1  out  32  operand 1 data
- RegR2  out  32  operand 2 data
- wb_valid  in  1  write-back request
- wb_ready  out  1  write-back accepted
- rd  in  5  write-back destination
- RegW  in  32  write-back data
- rf_en  out  1  register-file write enable; also selects rd onto the shared address port
- rf_addr  out  5  shared rs1/rd address
- rf_rs2  out  5  rs2 address
- rf_wdata  out  32  write data
- rf_rdata1  in  32  register-file read data 1 (combinational)
- rf_rdata2  in  32  register-file read data 2 (combinational)
- wbuf_empty  out  1  no pending write-backs

Behaviour:
- Reset (rst=0, async): buffer count/head/tail=0; rsp_valid=0; RegR1=RegR2=0; starve counter=0.
- Outputs during reset: rf_en=0, wb_ready=1, wbuf_empty=1.
- wb_ready = (count != DEPTH). It is registered-count based; a same-cycle drain does not free a slot.
- Write-backs with rd=0 are accepted and discarded (not enqueued).
- Drain condition: drain = (count!=0) && (!rd_req_valid || count==DEPTH || force).
- Drain cycle:
  - rf_en=1, rf_addr=head.rd, rf_wdata=head.data.
  - Head pops at the clock edge; the register file commits on its inverted clock within the cycle.
- rd_req_ready = !drain.
- Read cycle (rd_req_valid && rd_req_ready): rf_en=0, rf_addr=rs1, rf_rs2=rs2.
- Idle cycle (no read, no drain): rf_en=0, rf_addr=rs1, rf_rs2=rs2, rf_wdata=0.
- Read response:
  - Registered; rsp_valid=1 exactly one cycle after acceptance, else 0.
  - RegR1/RegR2 hold their last value when rsp_valid=0.
- Forwarding priority, per operand:
  1. x0 returns 0.
  2. A same-cycle accepted write-back with matching rd.
  3. The youngest matching buffer entry.
  4. rf_rdata.
- Simultaneous enqueue and drain: count unchanged, tail and head both advance, modulo DEPTH wrap.
- Full buffer with rd_req_valid: reads stall (drain has priority) until count<DEPTH.
- A write-back arriving while full stalls, with no loss.
- Reset mid-operation discards all pending writes; the register file is not flushed.

Optional Feature:
- Macro: RFSEQ_STARVE_LIMIT_EN.
- With the macro:
  - A starve counter increments each cycle with count!=0 and no drain; it clears on any drain.
  - When counter==STARVE_LIMIT-1, force=1 for one cycle, and that cycle drains even if rd_req_valid.
- Without the macro: force is tied 0, no counter exists, and the buffer drains only on idle or full.

Decomposition:
- Package rfseq_pkg:
  - XLEN=32, REG_AW=5.
  - Typedef wb_entry_t {logic [REG_AW-1:0] rd; logic [XLEN-1:0] data;}.
  - Function for youngest-match priority select.
- Sub-module rfseq_wbuf:
  - Circular FIFO with parallel address compare.
  - Outputs per-operand hit and youngest data.
  - Top-level holds arbitration, starve counter and response register.

Test Plan:
- Reset then read rs1=5, rs2=6 with register file preloaded 0x11/0x22 -> next cycle rsp_valid=1, RegR1=0x11, RegR2=0x22, rf_en never 1.
- wb rd=5, RegW=0xAAAA while reading rs1=5 in the same cycle -> RegR1=0xAAAA (bypass); after the first idle cycle rf_en=1, rf_addr=5, rf_wdata=0xAAAA.
- Two wb to rd=7 (0x1 then 0x2) with continuous reads of rs2=7 -> RegR2=0x2 (youngest); drains occur in order 0x1, 0x2 once reads stop.
- Fill buffer with 4 writes under continuous reads -> wb_ready=0 at count=4; rd_req_ready=0 for one drain cycle; a fifth wb is accepted the cycle after; head/tail wrap correctly.
- wb rd=0 RegW=0xFFFF -> wbuf_empty stays 1; a read of rs1=0 returns 0.
- With RFSEQ_STARVE_LIMIT_EN, STARVE_LIMIT=8, one pending write and continuous reads -> rd_req_ready=0 on the 8th cycle, rf_en=1, counter clears. Async rst asserted mid-drain -> count=0, rsp_valid=0 immediately.

Source files
------------

// File: rtl/rfseq_pkg.sv
// Shared types and helpers for the register-file port sequencer.
package rfseq_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  // Operand value by forwarding priority: x0, same-cycle write-back,
  // youngest buffered write-back, then the register file itself.
  function automatic logic [XLEN-1:0] operand_select(
    input logic [REG_AW-1:0] addr,
    input logic              wb_match,
    input logic [XLEN-1:0]   wb_data,
    input logic              buf_hit,
    input logic [XLEN-1:0]   buf_data,
    input logic [XLEN-1:0]   rf_data
  );
    if (addr == '0)    return '0;
    else if (wb_match) return wb_data;
    else if (buf_hit)  return buf_data;
    else               return rf_data;
  endfunction

endpackage

// File: rtl/rfseq_wbuf.sv
// Write-back buffer: circular FIFO with parallel address lookup that
// returns the youngest matching entry for each read operand.
module rfseq_wbuf
  import rfseq_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PW   = $clog2(DEPTH),
  localparam int unsigned CW   = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  wb_entry_t         push_entry_i,
  output wb_entry_t         head_o,
  output logic [CW-1:0]     count_o,
  input  logic [REG_AW-1:0] lookup1_i,
  input  logic [REG_AW-1:0] lookup2_i,
  output logic              hit1_o,
  output logic [XLEN-1:0]   data1_o,
  output logic              hit2_o,
  output logic [XLEN-1:0]   data2_o
);

  wb_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] idx;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) tail_q <= tail_q + PW'(1);
      if (pop_i)  head_q <= head_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Entry storage needs no reset: occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  // Scan oldest to youngest so the last match wins, giving the youngest value.
  always_comb begin
    hit1_o  = 1'b0;
    data1_o = '0;
    hit2_o  = 1'b0;
    data2_o = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if (mem_q[idx].rd == lookup1_i) begin
          hit1_o  = 1'b1;
          data1_o = mem_q[idx].data;
        end
        if (mem_q[idx].rd == lookup2_i) begin
          hit2_o  = 1'b1;
          data2_o = mem_q[idx].data;
        end
      end
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

endmodule

// File: rtl/regfile_port_sequencer.sv
// Register-file port sequencer: arbitrates operand reads against buffered
// write-back drains on a shared rs1/rd address port, forwarding pending data.
// Optional macro RFSEQ_STARVE_LIMIT_EN forces a drain after STARVE_LIMIT
// consecutive blocked cycles; without it the buffer drains only when idle or full.
module regfile_port_sequencer
  import rfseq_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   RegR1,
  output logic [XLEN-1:0]   RegR2,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [REG_AW-1:0] rd,
  input  logic [XLEN-1:0]   RegW,
  output logic              rf_en,
  output logic [REG_AW-1:0] rf_addr,
  output logic [REG_AW-1:0] rf_rs2,
  output logic [XLEN-1:0]   rf_wdata,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  output logic              wbuf_empty
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
    $error("regfile_port_sequencer: DEPTH must be a power of two >= 2 and STARVE_LIMIT >= 1");
  end

  wb_entry_t       head;
  wb_entry_t       push_entry;
  logic [CW-1:0]   count;
  logic            full, empty;
  logic            wb_accept, push, drain, read_fire, force_drain;
  logic            hit1, hit2;
  logic [XLEN-1:0] buf1, buf2, op1, op2;
  logic            rsp_valid_q;
  logic [XLEN-1:0] regr1_q, regr2_q;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Slot availability follows the registered count only, so a drain in the
  // same cycle never frees room for an incoming write-back.
  assign wb_ready   = !full;
  assign wb_accept  = wb_valid && wb_ready;
  assign push       = wb_accept && (rd != '0);
  assign push_entry = '{rd: rd, data: RegW};

  assign drain        = !empty && (!rd_req_valid || full || force_drain);
  assign rd_req_ready = !drain;
  assign read_fire    = rd_req_valid && !drain;

  rfseq_wbuf #(.DEPTH(DEPTH)) u_wbuf (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (drain),
    .push_entry_i (push_entry),
    .head_o       (head),
    .count_o      (count),
    .lookup1_i    (rs1),
    .lookup2_i    (rs2),
    .hit1_o       (hit1),
    .data1_o      (buf1),
    .hit2_o       (hit2),
    .data2_o      (buf2)
  );

  assign rf_en      = drain;
  assign rf_addr    = drain ? head.rd   : rs1;
  assign rf_wdata   = drain ? head.data : '0;
  assign rf_rs2     = rs2;
  assign wbuf_empty = empty;

  assign op1 = operand_select(rs1, wb_accept && (rd == rs1), RegW, hit1, buf1, rf_rdata1);
  assign op2 = operand_select(rs2, wb_accept && (rd == rs2), RegW, hit2, buf2, rf_rdata2);

`ifdef RFSEQ_STARVE_LIMIT_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;
  logic [SW-1:0] starve_q, starve_d;

  // Count consecutive cycles where pending writes are held off by reads.
  always_comb begin
    starve_d = starve_q;
    if (drain || empty) starve_d = '0;
    else                starve_d = starve_q + SW'(1);
  end

  // Starve counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= '0;
    else      starve_q <= starve_d;
  end

  assign force_drain = (starve_q == SW'(STARVE_LIMIT - 1));
`else
  assign force_drain = 1'b0;
`endif

  // Registered read response; operand data holds while no read is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      regr1_q     <= '0;
      regr2_q     <= '0;
    end else begin
      rsp_valid_q <= read_fire;
      if (read_fire) begin
        regr1_q <= op1;
        regr2_q <= op2;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign RegR1     = regr1_q;
  assign RegR2     = regr2_q;

endmodule
